// File: rtl/time_disp_scan.sv
// Six-digit multiplexed 7-segment driver for the sec/min/hr counter chain.
// It shows a frame-coherent snapshot, with blanking, leading-zero suppression and colon blink.
module time_disp_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int BLANK    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    s_sec_q, s_sec_d;
    logic [5:0]    s_min_q, s_min_d;
    logic [4:0]    s_hr_q, s_hr_d;
    logic          first_q, first_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    dig_q, dig_d;

    logic [6:0] sec_bcd_s, min_bcd_s, hr_bcd_s;
    logic       sec_ok_s, min_ok_s, hr_ok_s;
    logic [3:0] digit_s;
    logic       ok_s, lz_s, colon_s;

    // Returns {tens[2:0], units[3:0]}; only meaningful for v <= 59.
    function automatic logic [6:0] bcd_split(input logic [5:0] v);
        logic [5:0] r;
        logic [2:0] t;
        if (v >= 6'd50) begin
            r = v - 6'd50;
            t = 3'd5;
        end else if (v >= 6'd40) begin
            r = v - 6'd40;
            t = 3'd4;
        end else if (v >= 6'd30) begin
            r = v - 6'd30;
            t = 3'd3;
        end else if (v >= 6'd20) begin
            r = v - 6'd20;
            t = 3'd2;
        end else if (v >= 6'd10) begin
            r = v - 6'd10;
            t = 3'd1;
        end else begin
            r = v;
            t = 3'd0;
        end
        return {t, r[3:0]};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    assign sec_bcd_s = bcd_split(s_sec_q);
    assign min_bcd_s = bcd_split(s_min_q);
    assign hr_bcd_s  = bcd_split({1'b0, s_hr_q});
    assign sec_ok_s  = (s_sec_q <= 6'd59);
    assign min_ok_s  = (s_min_q <= 6'd59);
    assign hr_ok_s   = (s_hr_q <= 5'd23);

    // Prescaler, slot index and snapshot next-state.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        s_sec_d = s_sec_q;
        s_min_d = s_min_q;
        s_hr_d  = s_hr_q;
        first_d = first_q;
        if (first_q) begin
            s_sec_d = sec;
            s_min_d = min;
            s_hr_d  = hr;
            first_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == 3'd5) begin
                idx_d   = 3'd0;
                s_sec_d = sec;
                s_min_d = min;
                s_hr_d  = hr;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Digit selection for the current slot.
    always_comb begin
        digit_s = 4'd0;
        ok_s    = 1'b1;
        lz_s    = 1'b0;
        colon_s = 1'b0;
        case (idx_q)
            3'd0: begin
                digit_s = sec_bcd_s[3:0];
                ok_s    = sec_ok_s;
            end
            3'd1: begin
                digit_s = {1'b0, sec_bcd_s[6:4]};
                ok_s    = sec_ok_s;
            end
            3'd2: begin
                digit_s = min_bcd_s[3:0];
                ok_s    = min_ok_s;
                colon_s = 1'b1;
            end
            3'd3: begin
                digit_s = {1'b0, min_bcd_s[6:4]};
                ok_s    = min_ok_s;
            end
            3'd4: begin
                digit_s = hr_bcd_s[3:0];
                ok_s    = hr_ok_s;
                colon_s = 1'b1;
            end
            3'd5: begin
                digit_s = {1'b0, hr_bcd_s[6:4]};
                ok_s    = hr_ok_s;
                lz_s    = (s_hr_q < 5'd10);
            end
            default: begin
                digit_s = 4'd0;
                ok_s    = 1'b0;
            end
        endcase
    end

    // Output next-state; outputs stay dark until the first snapshot exists.
    always_comb begin
        seg_d = 7'h00;
        dp_d  = 1'b0;
        dig_d = 6'b000000;
        if (!first_q) begin
            if (lz_s) begin
                seg_d = 7'h00;
            end else if (!ok_s) begin
                seg_d = 7'h40;
            end else begin
                seg_d = glyph(digit_s);
            end
            dp_d = colon_s & ~s_sec_q[0] & ~lz_s;
            if (cnt_q < BLANK_C) begin
                dig_d = 6'b000000;
            end else begin
                case (idx_q)
                    3'd0:    dig_d = 6'b000001;
                    3'd1:    dig_d = 6'b000010;
                    3'd2:    dig_d = 6'b000100;
                    3'd3:    dig_d = 6'b001000;
                    3'd4:    dig_d = 6'b010000;
                    3'd5:    dig_d = 6'b100000;
                    default: dig_d = 6'b000000;
                endcase
            end
        end else begin
            seg_d = 7'h00;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            s_sec_q <= 6'd0;
            s_min_q <= 6'd0;
            s_hr_q  <= 5'd0;
            first_q <= 1'b1;
            seg_q   <= 7'h00;
            dp_q    <= 1'b0;
            dig_q   <= 6'b000000;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            s_sec_q <= s_sec_d;
            s_min_q <= s_min_d;
            s_hr_q  <= s_hr_d;
            first_q <= first_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign dig = dig_q;

endmodule

// File: tb/tb_time_disp_scan.sv
// Self-checking bench for time_disp_scan (SCAN_DIV=4, BLANK=1): vector table,
// hand-written corner sequences and random inputs against a frame-level reference model.
module tb_time_disp_scan;
    localparam int SD = 4;
    localparam int BL = 1;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] sec = 6'd0;
    logic [5:0] min = 6'd0;
    logic [4:0] hr  = 5'd0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int snap_s  = 0;
    int snap_m  = 0;
    int snap_h  = 0;
    int cur_slot = -1;
    int cur_c    = -1;
    logic [6:0] glyph_t [0:9];

    typedef struct {
        logic [5:0]      v_sec;
        logic [5:0]      v_min;
        logic [4:0]      v_hr;
        logic [5:0][6:0] segs;
        logic            colon;
    } vec_t;
    vec_t vecs [5];

    time_disp_scan #(.SCAN_DIV(SD), .BLANK(BL)) dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr),
        .seg(seg), .dp(dp), .dig(dig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: got {seg,dp,dig}=%h expected %h", name, k, got, exp);
        end
    endtask

    // Expected outputs after edge kk since reset release, from the snapshot in force.
    function automatic logic [13:0] model(int kk, int ss, int sm, int sh);
        int p, slot, c, v, lim, d;
        logic [6:0] s;
        logic pdp;
        logic [5:0] dg;
        if (kk < 2) return 14'd0;
        p = (kk - 2) % FRAME;
        slot = p / SD;
        c = p % SD;
        if (slot < 2) begin v = ss; lim = 59; end
        else if (slot < 4) begin v = sm; lim = 59; end
        else begin v = sh; lim = 23; end
        d = (slot % 2 == 1) ? v / 10 : v % 10;
        if (slot == 5 && sh < 10) s = 7'h00;
        else if (v > lim) s = 7'h40;
        else s = glyph_t[d];
        pdp = (slot == 2 || slot == 4) && (ss % 2 == 0);
        dg = (c >= BL) ? 6'(1 << slot) : 6'd0;
        return {s, pdp, dg};
    endfunction

    task automatic step();
        logic [13:0] e;
        @(posedge clk);
        k++;
        e = model(k, snap_s, snap_m, snap_h);
        if (k == 1 || (k - 1) % FRAME == 0) begin
            snap_s = int'(sec);
            snap_m = int'(min);
            snap_h = int'(hr);
        end
        if (k >= 2) begin
            cur_slot = ((k - 2) % FRAME) / SD;
            cur_c = (k - 2) % SD;
        end else begin
            cur_slot = -1;
            cur_c = -1;
        end
        #1;
        chk("model", {seg, dp, dig}, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset", {seg, dp, dig}, 14'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", {seg, dp, dig}, 14'd0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
    endtask

    // Startup with sec=37: dark edge, blanked idx0, then lit idx0 showing 7.
    task automatic startup_checks();
        step();
        chk("edge1", {seg, dp, dig}, 14'd0);
        step();
        chk("edge2", {seg, dp, dig}, {7'h07, 1'b0, 6'b000000});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("edge3_5", {seg, dp, dig}, {7'h07, 1'b0, 6'b000001});
        end
    endtask

    initial begin
        int on_cnt [6];
        glyph_t[0] = 7'h3F; glyph_t[1] = 7'h06; glyph_t[2] = 7'h5B; glyph_t[3] = 7'h4F;
        glyph_t[4] = 7'h66; glyph_t[5] = 7'h6D; glyph_t[6] = 7'h7D; glyph_t[7] = 7'h07;
        glyph_t[8] = 7'h7F; glyph_t[9] = 7'h6F;

        vecs[0] = '{6'd37, 6'd5,  5'd14, {7'h06, 7'h66, 7'h3F, 7'h6D, 7'h4F, 7'h07}, 1'b0};
        vecs[1] = '{6'd0,  6'd60, 5'd7,  {7'h00, 7'h07, 7'h40, 7'h40, 7'h3F, 7'h3F}, 1'b1};
        vecs[2] = '{6'd59, 6'd59, 5'd23, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 1'b0};
        vecs[3] = '{6'd59, 6'd59, 5'd24, {7'h40, 7'h40, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 1'b0};
        vecs[4] = '{6'd38, 6'd5,  5'd14, {7'h06, 7'h66, 7'h3F, 7'h6D, 7'h4F, 7'h7F}, 1'b1};

        // Reset/startup, then digit on-time over one full frame.
        sec = 6'd37; min = 6'd5; hr = 5'd14;
        do_reset();
        startup_checks();
        while (k < FRAME + 1) step();
        for (int b = 0; b < 6; b++) on_cnt[b] = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            for (int b = 0; b < 6; b++) if (dig[b]) on_cnt[b]++;
        end
        for (int b = 0; b < 6; b++) chk("dig_on_time", 14'(on_cnt[b]), 14'(SD - BL));

        // Vector table: first lit cycle of each slot in the first frame.
        for (int v = 0; v < 5; v++) begin
            sec = vecs[v].v_sec; min = vecs[v].v_min; hr = vecs[v].v_hr;
            do_reset();
            for (int i = 0; i < FRAME + 1; i++) begin
                step();
                if (cur_c == BL)
                    chk("vector", {seg, dp, dig},
                        {vecs[v].segs[cur_slot],
                         (cur_slot == 2 || cur_slot == 4) ? vecs[v].colon : 1'b0,
                         6'(1 << cur_slot)});
            end
        end

        // Snapshot coherence: sec changes 37->38 during slot idx1.
        sec = 6'd37; min = 6'd5; hr = 5'd14;
        do_reset();
        while (k < 6) step();
        sec = 6'd38;
        while (k < 2 * FRAME + 1) begin
            step();
            if (k == 8 || k == 9) chk("coh_old", {seg, dp, dig}, {7'h4F, 1'b0, 6'b000010});
            if (k == 27) chk("coh_new_u", {seg, dp, dig}, {7'h7F, 1'b0, 6'b000001});
            if (k == 31) chk("coh_new_t", {seg, dp, dig}, {7'h4F, 1'b0, 6'b000010});
            if (k == 35) chk("coh_dp2", {seg, dp, dig}, {7'h6D, 1'b1, 6'b000100});
            if (k == 43) chk("coh_dp4", {seg, dp, dig}, {7'h66, 1'b1, 6'b010000});
        end

        // Mid-frame reset at idx3/cnt2, then the startup sequence again.
        sec = 6'd37; min = 6'd5; hr = 5'd14;
        do_reset();
        while (k < 15) step();
        chk("pre_midreset", {seg, dp, dig}, {7'h3F, 1'b0, 6'b001000});
        do_reset();
        startup_checks();

        // Random inputs, including out-of-range values, against the model.
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) begin
                sec = 6'($urandom_range(0, 63));
                min = 6'($urandom_range(0, 63));
                hr  = 5'($urandom_range(0, 31));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
